// File: rtl/dec_pkg.sv
// Shared types for the dwell decoder: FSM states, default widths and the buffered item.
package dec_pkg;

    localparam int unsigned CODE_W_DEF  = 3;
    localparam int unsigned DWELL_W_DEF = 4;

    typedef enum logic [0:0] {
        IDLE,
        DWELL
    } dec_state_t;

    typedef struct packed {
        logic [CODE_W_DEF-1:0]  code;
        logic [DWELL_W_DEF-1:0] dwell;
    } dec_item_t;

endpackage

// File: rtl/dec_skid_fifo.sv
// Two-entry FIFO of decoder items; dout shows the head whenever fill is non-zero.
module dec_skid_fifo
    import dec_pkg::*;
#(
    parameter type item_t = dec_item_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  item_t      din,
    input  logic       pop,
    output item_t      dout,
    output logic [1:0] fill
);

    item_t      mem_q [2];
    logic       wr_q;
    logic       rd_q;
    logic [1:0] fill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            fill_q   <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= din;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            case ({push, pop})
                2'b10:   fill_q <= fill_q + 2'd1;
                2'b01:   fill_q <= fill_q - 2'd1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    assign dout = mem_q[rd_q];
    assign fill = fill_q;

endmodule

// File: rtl/prdecoder_dwell.sv
// Registered code-to-one-hot decoder that holds each line for a programmable dwell.
// Define DEC_BUF_EN to add a 2-entry input buffer so consecutive items run without gaps.
module prdecoder_dwell
    import dec_pkg::*;
#(
    parameter int unsigned CODE_W  = CODE_W_DEF,
    parameter int unsigned DWELL_W = DWELL_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CODE_W-1:0]    in_code,
    input  logic [DWELL_W-1:0]   in_dwell,
    output logic [2**CODE_W-1:0] out,
    output logic                 out_active,
    output logic                 done
);

    localparam int unsigned LINES = 2**CODE_W;

    dec_state_t         state_q, state_d;
    logic [LINES-1:0]   out_q, out_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               run_q;
    logic               xfer;
    logic               last;
    logic               load;
    logic [CODE_W-1:0]  ld_code;
    logic [DWELL_W-1:0] ld_dwell;

`ifdef DEC_BUF_EN
    typedef struct packed {
        logic [CODE_W-1:0]  code;
        logic [DWELL_W-1:0] dwell;
    } item_t;

    item_t      in_item;
    item_t      head;
    logic       push;
    logic       pop;
    logic [1:0] fill;

    assign in_item  = {in_code, in_dwell};
    assign in_ready = run_q && (fill != 2'd2);

    dec_skid_fifo #(
        .item_t(item_t)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .din  (in_item),
        .pop  (pop),
        .dout (head),
        .fill (fill)
    );
`else
    assign in_ready = run_q && (state_q == IDLE);
`endif

    assign xfer = in_valid && in_ready;
    assign last = (state_q == DWELL) && (cnt_q == DWELL_W'(1));

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        ld_code  = in_code;
        ld_dwell = in_dwell;
`ifdef DEC_BUF_EN
        push = 1'b0;
        pop  = 1'b0;
        if (state_q == IDLE || last) begin
            if (fill != 2'd0) begin
                load     = 1'b1;
                pop      = 1'b1;
                push     = xfer;
                ld_code  = head.code;
                ld_dwell = head.dwell;
            end else begin
                // Empty buffer: the incoming item goes straight to the output stage.
                load = xfer;
            end
        end else begin
            push = xfer;
        end
`else
        load = (state_q == IDLE) && xfer;
`endif
        if (load) begin
            state_d          = DWELL;
            out_d            = '0;
            out_d[ld_code]   = 1'b1;
            cnt_d            = (ld_dwell == '0) ? DWELL_W'(1) : ld_dwell;
        end else if (last) begin
            state_d = IDLE;
            out_d   = '0;
            cnt_d   = '0;
        end else if (state_q == DWELL) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
        end
    end

    assign out        = out_q;
    assign out_active = |out_q;
    assign done       = last;

endmodule

// File: tb/tb_prdecoder_dwell.sv
// Directed self-checking bench for prdecoder_dwell; adapts to the DEC_BUF_EN build.
module tb_prdecoder_dwell;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_code = '0;
    logic [3:0] in_dwell = '0;
    logic       in_ready;
    logic [7:0] out;
    logic       out_active;
    logic       done;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    prdecoder_dwell #(
        .CODE_W (3),
        .DWELL_W(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_dwell  (in_dwell),
        .out       (out),
        .out_active(out_active),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) chk(tag, 8'(in_ready), 8'd1);
    endtask

    // Returns in the first cycle the item is on the output.
    task automatic send(input logic [2:0] code, input logic [3:0] dwell, input string tag);
        in_code  = code;
        in_dwell = dwell;
        in_valid = 1'b1;
        wait_ready(tag);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] e;
        int held;
        int n;

        // Reset values
        #2;
        chk("rst_out", out, 8'h00);
        chk("rst_active", 8'(out_active), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_ready", 8'(in_ready), 8'd0);
        tick();
        chk("rst_ready_clk", 8'(in_ready), 8'd0);
        #4 rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 8'(in_ready), 8'd1);
        chk("post_rst_out", out, 8'h00);

        // Basic decode: code 5, dwell 3
        send(3'd5, 4'd3, "basic_wait");
        chk("basic_c1", out, 8'h20);
        chk("basic_c1_act", 8'(out_active), 8'd1);
        chk("basic_c1_done", 8'(done), 8'd0);
        tick();
        chk("basic_c2", out, 8'h20);
        chk("basic_c2_done", 8'(done), 8'd0);
        tick();
        chk("basic_c3", out, 8'h20);
        chk("basic_c3_done", 8'(done), 8'd1);
        tick();
        chk("basic_c4", out, 8'h00);
        chk("basic_c4_act", 8'(out_active), 8'd0);
        chk("basic_c4_done", 8'(done), 8'd0);

        // Max dwell: code 7, dwell 15
        send(3'd7, 4'd15, "max_wait");
        for (int i = 1; i <= 15; i++) begin
            chk("max_out", out, 8'h80);
            chk("max_done", 8'(done), (i == 15) ? 8'd1 : 8'd0);
            tick();
        end
        chk("max_after", out, 8'h00);
        chk("max_after_done", 8'(done), 8'd0);

        // Dwell zero sweep over all codes
`ifdef DEC_BUF_EN
        in_dwell = 4'd0;
        in_code  = 3'd0;
        in_valid = 1'b1;
        wait_ready("sweep_wait");
        for (int c = 0; c < 8; c++) begin
            in_code = 3'(c);
            tick();
            e = 8'd1 << c;
            chk("sweep_out", out, e);
            chk("sweep_done", 8'(done), 8'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("sweep_end", out, 8'h00);
`else
        for (int c = 0; c < 8; c++) begin
            send(3'(c), 4'd0, "sweep_wait");
            e = 8'd1 << c;
            chk("sweep_out", out, e);
            chk("sweep_done", 8'(done), 8'd1);
            tick();
            chk("sweep_gap", out, 8'h00);
        end
`endif

`ifdef DEC_BUF_EN
        // Back-pressure: A active, B and C queued behind it
        send(3'd1, 4'd15, "bp_wait");
        chk("bp_a", out, 8'h02);
        held = 1;
        in_valid = 1'b1;
        in_code  = 3'd2;
        in_dwell = 4'd2;
        chk("bp_ready_b", 8'(in_ready), 8'd1);
        tick();
        if (out == 8'h02) held++;
        in_code = 3'd3;
        chk("bp_ready_c", 8'(in_ready), 8'd1);
        tick();
        if (out == 8'h02) held++;
        in_code = 3'd4;
        n = 0;
        while (out == 8'h02 && n < 40) begin
            chk("bp_full", 8'(in_ready), 8'd0);
            if (held == 15) chk("bp_a_done", 8'(done), 8'd1);
            tick();
            n++;
            if (out == 8'h02) held++;
        end
        in_valid = 1'b0;
        chk("bp_a_len", 8'(held), 8'd15);
        chk("bp_b1", out, 8'h04);
        chk("bp_ready_back", 8'(in_ready), 8'd1);
        tick();
        chk("bp_b2", out, 8'h04);
        chk("bp_b2_done", 8'(done), 8'd1);
        tick();
        chk("bp_c1", out, 8'h08);
        chk("bp_c1_ready", 8'(in_ready), 8'd1);
        tick();
        chk("bp_c2", out, 8'h08);
        chk("bp_c2_done", 8'(done), 8'd1);
        tick();
        chk("bp_end", out, 8'h00);
`endif

        // Reset in cycle 2 of a dwell-10 item
        send(3'd3, 4'd10, "mid_wait");
`ifdef DEC_BUF_EN
        in_valid = 1'b1;
        in_code  = 3'd6;
        in_dwell = 4'd1;
        tick();
        in_valid = 1'b0;
`else
        tick();
`endif
        chk("mid_out", out, 8'h08);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out", out, 8'h00);
        chk("mid_rst_act", 8'(out_active), 8'd0);
        chk("mid_rst_done", 8'(done), 8'd0);
        chk("mid_rst_ready", 8'(in_ready), 8'd0);
        #3 rst_n = 1'b1;
        tick();
        chk("mid_rel_ready", 8'(in_ready), 8'd1);
        for (int i = 0; i < 12; i++) begin
            chk("mid_quiet", out, 8'h00);
            tick();
        end

        // Normal operation resumes after reset
        send(3'd2, 4'd1, "resume_wait");
        chk("resume_out", out, 8'h04);
        chk("resume_done", 8'(done), 8'd1);
        tick();
        chk("resume_end", out, 8'h00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
